// File: rtl/sift_pkg.sv
//------------------------------------------------------------------------------
// sift_pkg : shared types and helpers for the SIFT keypoint pipeline
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sift_pkg;

  localparam int DEF_OCTAVE_BITS = 2;
  localparam int DEF_CW          = 6;

  localparam logic LAYER_FIRST  = 1'b0;
  localparam logic LAYER_SECOND = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } kpw_state_t;

  // Field layout of one BRAM word at the default widths
  typedef struct packed {
    logic [DEF_OCTAVE_BITS-1:0] octave;
    logic                       layer;
    logic [DEF_CW-1:0]          y;
    logic [DEF_CW-1:0]          x;
  } keypoint_t;

  function automatic int kpw(input int octave_bits, input int cw);
    return octave_bits + 1 + 2 * cw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kp_event_fifo.sv
//------------------------------------------------------------------------------
// kp_event_fifo : 2-write / 1-read synchronous FIFO with flush and occupancy
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module kp_event_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             flush,
  input  logic             push0,
  input  logic [WIDTH-1:0] din0,
  input  logic             push1,
  input  logic [WIDTH-1:0] din1,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      occupancy
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_occ;
  logic [AW-1:0]    w_wptr1;
  logic [1:0]       w_npush;

  // push1 is only ever asserted together with push0, so slots stay contiguous
  assign w_wptr1   = r_wptr + AW'(1);
  assign w_npush   = {1'b0, push0} + {1'b0, push1};
  assign dout      = r_mem[r_rptr];
  assign occupancy = r_occ;

  always_ff @(posedge clk) begin
    if (!rst_in && !flush) begin
      if (push0) r_mem[r_wptr]  <= din0;
      if (push1) r_mem[w_wptr1] <= din1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      r_wptr <= r_wptr + AW'(w_npush);
      r_rptr <= r_rptr + AW'(pop);
      r_occ  <= r_occ + (AW+1)'(w_npush) - (AW+1)'(pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/keypoint_writer.sv
//------------------------------------------------------------------------------
// keypoint_writer : tags extrema from check_extrema and writes them to BRAM
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module keypoint_writer
  import sift_pkg::*;
#(
  parameter int DIMENSION     = 64,
  parameter int MAX_KEYPOINTS = 1024,
  parameter int FIFO_DEPTH    = 4,
  parameter int OCTAVE_BITS   = 2,
  localparam int CW  = $clog2(DIMENSION),
  localparam int AW  = $clog2(MAX_KEYPOINTS),
  localparam int KPW = kpw(OCTAVE_BITS, CW)
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   start,
  input  logic [OCTAVE_BITS-1:0] octave,
  input  logic [CW-1:0]          x,
  input  logic [CW-1:0]          y,
  input  logic                   first_is_extremum,
  input  logic                   second_is_extremum,
  input  logic                   done_checking,
  output logic [AW-1:0]          kp_addr,
  output logic [KPW-1:0]         kp_data,
  output logic                   kp_we,
  output logic [AW:0]            keypoint_count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done
);

  localparam int EW = 1 + 2 * CW;
  localparam int OW = $clog2(FIFO_DEPTH) + 1;

  kpw_state_t             r_state;
  logic [OCTAVE_BITS-1:0] r_octave;
  logic [OW-1:0]          w_occ;
  logic [OW-1:0]          w_free;
  logic [EW-1:0]          w_head;
  logic [EW-1:0]          w_entry_f;
  logic [EW-1:0]          w_entry_s;
  logic [EW-1:0]          w_din0;
  logic                   w_pop, w_f, w_s, w_push0, w_push1, w_drop, w_cap;

  assign w_pop  = (w_occ != '0);
  // Slots available this cycle, counting the one freed by the concurrent pop
  assign w_free = OW'(FIFO_DEPTH) - w_occ + OW'(w_pop);

  assign w_f = (r_state == ST_COLLECT) && !start && first_is_extremum;
  assign w_s = (r_state == ST_COLLECT) && !start && second_is_extremum;

  assign w_entry_f = {LAYER_FIRST, y, x};
  assign w_entry_s = {LAYER_SECOND, y, x};
  assign w_din0    = w_f ? w_entry_f : w_entry_s;

  assign w_push0 = (w_f || w_s) && (w_free >= OW'(1));
  assign w_push1 = w_f && w_s && (w_free >= OW'(2));
  assign w_drop  = ((w_f || w_s) && !w_push0) || (w_f && w_s && !w_push1);
  assign w_cap   = (keypoint_count == (AW+1)'(MAX_KEYPOINTS));

  kp_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_in    (rst_in),
    .flush     (start),
    .push0     (w_push0),
    .din0      (w_din0),
    .push1     (w_push1),
    .din1      (w_entry_s),
    .pop       (w_pop),
    .dout      (w_head),
    .occupancy (w_occ)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state        <= ST_IDLE;
      r_octave       <= '0;
      kp_addr        <= '0;
      kp_data        <= '0;
      kp_we          <= 1'b0;
      keypoint_count <= '0;
      overflow       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else if (start) begin
      r_state        <= ST_COLLECT;
      r_octave       <= octave;
      kp_we          <= 1'b0;
      keypoint_count <= '0;
      overflow       <= 1'b0;
      busy           <= 1'b1;
      done           <= 1'b0;
    end else begin
      kp_we <= 1'b0;
      done  <= 1'b0;
      if (w_pop) begin
        if (!w_cap) begin
          kp_we          <= 1'b1;
          kp_addr        <= keypoint_count[AW-1:0];
          kp_data        <= {r_octave, w_head};
          keypoint_count <= keypoint_count + (AW+1)'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
      if (w_drop) overflow <= 1'b1;
      case (r_state)
        ST_COLLECT: if (done_checking) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (w_occ == '0) begin
            r_state <= ST_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypoint_writer.sv
//------------------------------------------------------------------------------
// tb_keypoint_writer : directed self-checking bench for keypoint_writer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_keypoint_writer;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       start = 1'b0;
  logic [1:0] octave = '0;
  logic [5:0] x = '0;
  logic [5:0] y = '0;
  logic       first = 1'b0;
  logic       second = 1'b0;
  logic       done_checking = 1'b0;

  logic [9:0]  kp_addr;
  logic [14:0] kp_data;
  logic        kp_we;
  logic [10:0] keypoint_count;
  logic        overflow, busy, done;

  logic [1:0]  kp_addr_c;
  logic [14:0] kp_data_c;
  logic        kp_we_c;
  logic [2:0]  keypoint_count_c;
  logic        overflow_c, busy_c, done_c;

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0]  wq_addr[$];
  logic [14:0] wq_data[$];
  logic [1:0]  cq_addr[$];
  logic [14:0] cq_data[$];

  always #5 clk = ~clk;

  keypoint_writer dut (
    .clk(clk), .rst_in(rst_in), .start(start), .octave(octave), .x(x), .y(y),
    .first_is_extremum(first), .second_is_extremum(second),
    .done_checking(done_checking), .kp_addr(kp_addr), .kp_data(kp_data),
    .kp_we(kp_we), .keypoint_count(keypoint_count), .overflow(overflow),
    .busy(busy), .done(done)
  );

  keypoint_writer #(.MAX_KEYPOINTS(4)) dut_cap (
    .clk(clk), .rst_in(rst_in), .start(start), .octave(octave), .x(x), .y(y),
    .first_is_extremum(first), .second_is_extremum(second),
    .done_checking(done_checking), .kp_addr(kp_addr_c), .kp_data(kp_data_c),
    .kp_we(kp_we_c), .keypoint_count(keypoint_count_c), .overflow(overflow_c),
    .busy(busy_c), .done(done_c)
  );

  always @(posedge clk) begin
    #1;
    if (kp_we === 1'b1) begin
      wq_addr.push_back(kp_addr);
      wq_data.push_back(kp_data);
    end
    if (kp_we_c === 1'b1) begin
      cq_addr.push_back(kp_addr_c);
      cq_data.push_back(kp_data_c);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic begin_run(input logic [1:0] oct);
    wq_addr.delete(); wq_data.delete();
    cq_addr.delete(); cq_data.delete();
    start = 1'b1; octave = oct;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int n = 0;
    done_checking = 1'b1;
    tick();
    done_checking = 1'b0;
    while (done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_we", {31'd0, kp_we}, 32'd0);
    chk("rst_count", {21'd0, keypoint_count}, 32'd0);
    chk("rst_flags", {28'd0, overflow, busy, done, 1'b0}, 32'd0);
    chk("rst_addr_data", {7'd0, kp_addr, kp_data}, 32'd0);
    rst_in = 1'b0;
    tick();

    // Single event
    begin_run(2'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    first = 1'b1; x = 6'd3; y = 6'd5;
    tick(); first = 1'b0;
    tick();
    chk("t1_we", {31'd0, kp_we}, 32'd1);
    chk("t1_addr", {22'd0, kp_addr}, 32'd0);
    chk("t1_data", {17'd0, kp_data}, {17'd0, 2'd1, 1'b0, 6'd5, 6'd3});
    chk("t1_count", {21'd0, keypoint_count}, 32'd1);
    done_checking = 1'b1;
    tick(); done_checking = 1'b0;
    chk("t1_we_low", {31'd0, kp_we}, 32'd0);
    chk("t1_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy_drop", {31'd0, busy}, 32'd0);
    chk("t1_final_count", {21'd0, keypoint_count}, 32'd1);
    tick();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);

    // Both flags in one cycle
    begin_run(2'd2);
    first = 1'b1; second = 1'b1; x = 6'd10; y = 6'd20;
    tick(); first = 1'b0; second = 1'b0;
    tick();
    chk("t2_w0", {7'd0, kp_we, kp_addr, kp_data}, {7'd0, 1'b1, 10'd0, 2'd2, 1'b0, 6'd20, 6'd10});
    tick();
    chk("t2_w1", {7'd0, kp_we, kp_addr, kp_data}, {7'd0, 1'b1, 10'd1, 2'd2, 1'b1, 6'd20, 6'd10});
    finish_run("t2_done");
    chk("t2_count", {21'd0, keypoint_count}, 32'd2);
    chk("t2_overflow", {31'd0, overflow}, 32'd0);
    tick();

    // done_checking coincident with a flag
    begin_run(2'd3);
    first = 1'b1; x = 6'd63; y = 6'd63; done_checking = 1'b1;
    tick(); first = 1'b0; done_checking = 1'b0;
    tick();
    chk("t3_write", {7'd0, kp_we, kp_addr, kp_data}, {7'd0, 1'b1, 10'd0, 2'd3, 1'b0, 6'd63, 6'd63});
    chk("t3_done_not_yet", {31'd0, done}, 32'd0);
    tick();
    chk("t3_done_after_write", {30'd0, done, kp_we}, {30'd0, 1'b1, 1'b0});
    chk("t3_count", {21'd0, keypoint_count}, 32'd1);
    tick(); tick();

    // FIFO overflow: double events on 4 consecutive cycles
    begin_run(2'd0);
    for (int k = 0; k < 4; k++) begin
      first = 1'b1; second = 1'b1; x = 6'(k + 1); y = 6'(k + 2);
      tick();
    end
    first = 1'b0; second = 1'b0;
    finish_run("t4_done");
    chk("t4_nwrites", wq_addr.size(), 32'd7);
    chk("t4_count", {21'd0, keypoint_count}, 32'd7);
    chk("t4_overflow", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 7 && i < wq_addr.size(); i++) begin
      chk($sformatf("t4_w%0d", i), {7'd0, wq_addr[i], wq_data[i]},
          {7'd0, 10'(i), 2'd0, 1'(i % 2), 6'(i / 2 + 2), 6'(i / 2 + 1)});
    end
    tick();

    // Count cap on the MAX_KEYPOINTS=4 instance
    begin_run(2'd0);
    for (int i = 0; i < 6; i++) begin
      first = 1'b1; x = 6'(i); y = 6'd7;
      tick();
    end
    first = 1'b0;
    finish_run("t5_done");
    chk("t5_cap_done", {31'd0, done_c}, 32'd1);
    chk("t5_cap_nwrites", cq_addr.size(), 32'd4);
    chk("t5_cap_count", {29'd0, keypoint_count_c}, 32'd4);
    chk("t5_cap_overflow", {31'd0, overflow_c}, 32'd1);
    chk("t5_main_count", {21'd0, keypoint_count}, 32'd6);
    for (int i = 0; i < 4 && i < cq_addr.size(); i++) begin
      chk($sformatf("t5_w%0d", i), {15'd0, cq_addr[i], cq_data[i]},
          {15'd0, 2'(i), 2'd0, 1'b0, 6'd7, 6'(i)});
    end
    tick();

    // Reset in the middle of DRAIN
    begin_run(2'd1);
    first = 1'b1; second = 1'b1; x = 6'd9; y = 6'd9;
    tick();
    done_checking = 1'b1;
    tick();
    first = 1'b0; second = 1'b0; done_checking = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("t6_rst_outputs", {3'd0, kp_we, keypoint_count, overflow, busy, done, 15'd0},
        32'd0);
    chk("t6_rst_addr_data", {7'd0, kp_addr, kp_data}, 32'd0);
    wq_addr.delete(); wq_data.delete();
    tick(); tick(); tick();
    chk("t6_no_writes", wq_addr.size(), 32'd0);
    begin_run(2'd1);
    first = 1'b1; x = 6'd4; y = 6'd2;
    tick(); first = 1'b0;
    finish_run("t6_done");
    chk("t6_nwrites", wq_addr.size(), 32'd1);
    if (wq_addr.size() > 0)
      chk("t6_addr", {22'd0, wq_addr[0]}, 32'd0);
    chk("t6_count", {21'd0, keypoint_count}, 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypoint_writer.md
# keypoint_writer

Downstream consumer of `check_extrema`. It captures every extremum flagged during a scan, whether from the first or second DoG layer, and tags it with its coordinates, layer and octave. It serialises the tagged keypoints through a small FIFO into a single-port keypoint BRAM, one write per cycle. It counts the keypoints written and signals completion once `check_extrema` is done and every pending keypoint has been written.

## Interface

Parameters:
- `DIMENSION`, 64: image side in pixels. Coordinate width is `CW = $clog2(DIMENSION)`.
- `MAX_KEYPOINTS`, 1024: keypoint BRAM depth and the hard cap on writes.
- `FIFO_DEPTH`, 4: depth of the internal event FIFO, a power of 2 and ≥ 2.
- `OCTAVE_BITS`, 2: width of the octave tag.

Ports:
- `clk`, in, 1: the single clock.
- `rst_in`, in, 1: reset. Synchronous, active-high.
- `start`, in, 1: one-cycle pulse that begins a collection run and clears the count.
- `octave`, in, `OCTAVE_BITS`: octave tag. Sampled on `start` and held for the run.
- `x`, in, `CW`: pixel x coordinate from `check_extrema`.
- `y`, in, `CW`: pixel y coordinate from `check_extrema`.
- `first_is_extremum`, in, 1: extremum in the first DoG layer at (`x`,`y`).
- `second_is_extremum`, in, 1: extremum in the second DoG layer at (`x`,`y`).
- `done_checking`, in, 1: `check_extrema` has finished its scan.
- `kp_addr`, out, `$clog2(MAX_KEYPOINTS)`: keypoint BRAM write address.
- `kp_data`, out, `KPW = OCTAVE_BITS+1+2*CW`: packed as {octave, layer, y, x}.
- `kp_we`, out, 1: BRAM write enable.
- `keypoint_count`, out, `$clog2(MAX_KEYPOINTS)+1`: number of keypoints written in this run.
- `overflow`, out, 1: sticky. Set when any keypoint was dropped.
- `busy`, out, 1: high while in COLLECT or DRAIN.
- `done`, out, 1: one-cycle pulse at the end of a run.

## Operation

States and transitions:
- **IDLE**: waits for `start`. On `start`, clears the FIFO, count and `overflow`, latches `octave`, and moves to COLLECT.
- **COLLECT**: accepts flag pulses. On `done_checking`, moves to DRAIN. Flags present in the same cycle as `done_checking` are still accepted.
- **DRAIN**: accepts no new flags. Once the FIFO is empty and no write is pending, moves to DONE.
- **DONE**: pulses `done` for one cycle, then returns to IDLE.

Capture rules:
- Flags are sampled only in COLLECT. Each set flag pushes one entry {layer, y, x}, with layer 0 for first and 1 for second.
- When both flags are set in one cycle, the first-layer entry is pushed ahead of the second.

FIFO rules:
- Pop rule: one pop per cycle whenever the registered occupancy is > 0.
- Push acceptance: a push is accepted only while occupancy − pop + accepted pushes ≤ `FIFO_DEPTH`.
- With exactly one free slot and both flags set, the first-layer entry is accepted and the second is dropped, which sets `overflow`.

Write rules:
- Each pop produces one write: `kp_we`=1, `kp_addr`=`keypoint_count`, `kp_data`={latched octave, entry}. `keypoint_count` then increments.
- Once `keypoint_count` == `MAX_KEYPOINTS`, popped entries are discarded, `kp_we` stays 0, and `overflow` is set.

Other rules:
- `start` while not in IDLE restarts the run: FIFO flushed, count cleared, state set to COLLECT.
- `done_checking` or flags seen in IDLE or DONE are ignored.

## Timing

- All outputs are registered.
- Reset values: every output is 0, state is IDLE, the FIFO is empty, and the latched octave is 0.
- Latency: a flag sampled at edge t produces a write with `kp_we` high after edge t+1. When both flags are set and the FIFO was empty, the second-layer write follows after edge t+2.
- Sustained throughput is one write per cycle. Bursts are absorbed up to `FIFO_DEPTH`.
- `done` asserts in the cycle after the last `kp_we`, or the cycle after entering DRAIN if nothing is pending. `busy` drops in the same cycle.
- `keypoint_count` is final when `done` is high and holds until the next `start` or reset.
- `rst_in` mid-run aborts immediately with no further writes. The next `start` begins from count 0.

## Structure

- Package `sift_pkg` holds:
  - the `KPW` width function;
  - packed struct `keypoint_t` {octave, layer, y, x};
  - the state enum `kpw_state_t`;
  - the layer constants `LAYER_FIRST`=0 and `LAYER_SECOND`=1.
- Sub-module `kp_event_fifo`: 2-write/1-read synchronous FIFO with occupancy output and a flush input, parameterised on width and depth.
- Top level: FSM, acceptance logic, counter and BRAM output registers.

## Test plan

- **Single event**: `start` with octave=1, then `first_is_extremum` at (3,5) → one write, addr 0, data {1,0,5,3}; `done_checking` → `done` pulse with count=1.
- **Both flags**: both flags set at (10,20) → writes on consecutive cycles, addr 0 layer 0 then addr 1 layer 1, both at (10,20); count=2; `overflow`=0.
- **done_checking with events**: `done_checking` in the same cycle as a flag at (63,63) → that keypoint is still written, and `done` asserts one cycle after its write.
- **FIFO overflow**: double events on 4 consecutive cycles with `FIFO_DEPTH`=4 → 7 writes; the second-layer entry of cycle 4 is dropped; `overflow`=1.
- **Count cap**: `MAX_KEYPOINTS`=4 and 6 single events → exactly 4 writes at addr 0–3; count=4; `overflow`=1; `done` still pulses.
- **Reset mid-DRAIN**: assert `rst_in` mid-DRAIN → all outputs 0 the next cycle with no further `kp_we`; a new `start` with one event → write at addr 0, count=1.
